// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and default limits for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_TIMEOUT      = 16;
    localparam int DEFAULT_STARVE_LIMIT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_EXT     = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    function automatic logic is_transfer(input arb_state_t s);
        return (s == ST_DATA) || (s == ST_FETCH) || (s == ST_EXT);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait-state counter for one memory transfer; strobes expired on the last
// permitted cycle without a ready.
module mem_port_arbiter_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between core fetch, core data and an
// external master, and stalls the core while its accesses are outstanding.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    input  logic        d_rd_i,
    input  logic [3:0]  d_wr_en_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        pause_o,
    input  logic        ext_req_i,
    input  logic [31:0] ext_addr_i,
    input  logic [3:0]  ext_wr_en_i,
    input  logic [31:0] ext_wdata_i,
    output logic        ext_gnt_o,
    output logic        ext_done_o,
    output logic [31:0] ext_rdata_o,
    output logic        mem_cs_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wr_en_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        err_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    arb_state_t    eff_state;
    arb_state_t    next_state;
    logic          data_done;
    logic          fetch_done;
    logic [SW-1:0] starve_cnt;
    logic          data_pend;
    logic          fetch_pend;
    logic          core_pend;
    logic          active;
    logic          timed_out;
    logic          xfer_done;
    logic [31:0]   cap_data;

    assign data_pend  = d_rd_i || (d_wr_en_i != 4'd0);
    assign fetch_pend = if_req_i;
    assign core_pend  = data_pend || fetch_pend;

    // IDLE arbitrates in the same cycle it is occupied, so a steady core
    // stream costs only the transfer cycles plus the RELEASE cycle.
    always_comb begin
        eff_state = state;
        if (!rst) begin
            eff_state = ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (ext_req_i && (starve_cnt == SW'(STARVE_LIMIT))) begin
                eff_state = ST_EXT;
            end else if (data_pend && !data_done) begin
                eff_state = ST_DATA;
            end else if (fetch_pend && !fetch_done) begin
                eff_state = ST_FETCH;
            end else if (ext_req_i) begin
                eff_state = ST_EXT;
            end
        end
    end

    assign active    = is_transfer(eff_state);
    assign xfer_done = active && (mem_ready_i || timed_out);
    assign cap_data  = mem_ready_i ? mem_rdata_i : 32'h0;

    always_comb begin
        next_state = eff_state;
        case (eff_state)
            ST_DATA: begin
                if (xfer_done) begin
                    next_state = (fetch_pend && !fetch_done) ? ST_FETCH : ST_RELEASE;
                end
            end
            ST_FETCH: begin
                if (xfer_done) begin
                    next_state = ST_RELEASE;
                end
            end
            ST_EXT: begin
                if (xfer_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    mem_port_arbiter_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!active || xfer_done),
        .enable (active && !mem_ready_i),
        .expired(timed_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            data_done  <= 1'b0;
            fetch_done <= 1'b0;
            starve_cnt <= '0;
            if_data_o  <= 32'h0;
            d_rdata_o  <= 32'h0;
        end else begin
            state <= next_state;
            case (eff_state)
                ST_DATA: begin
                    if (xfer_done) begin
                        data_done <= 1'b1;
                        if (d_wr_en_i == 4'd0) begin
                            d_rdata_o <= cap_data;
                        end
                    end
                end
                ST_FETCH: begin
                    if (xfer_done) begin
                        fetch_done <= 1'b1;
                        if_data_o  <= cap_data;
                    end
                end
                ST_EXT: starve_cnt <= '0;
                ST_RELEASE: begin
                    data_done  <= 1'b0;
                    fetch_done <= 1'b0;
                    if (ext_req_i && (starve_cnt != SW'(STARVE_LIMIT))) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr_o  = 32'h0;
        mem_wr_en_o = 4'd0;
        mem_wdata_o = 32'h0;
        case (eff_state)
            ST_DATA: begin
                mem_addr_o  = d_addr_i;
                mem_wr_en_o = d_wr_en_i;
                mem_wdata_o = d_wdata_i;
            end
            ST_FETCH: mem_addr_o = if_addr_i;
            ST_EXT: begin
                mem_addr_o  = ext_addr_i;
                mem_wr_en_o = ext_wr_en_i;
                mem_wdata_o = ext_wdata_i;
            end
            default: ;
        endcase
    end

    assign mem_cs_o    = active;
    assign ext_gnt_o   = (eff_state == ST_EXT);
    assign ext_done_o  = ext_gnt_o && xfer_done;
    assign ext_rdata_o = ext_done_o ? cap_data : 32'h0;
    assign err_o       = active && timed_out;
    assign pause_o     = rst && core_pend && (eff_state != ST_RELEASE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (zz bus) between three requesters: core instruction fetch, core data access, and an external DMA/debug master.
- Generates the core-wide pause so the pipeline stalls while its fetch or data access is still outstanding.
- Sits between mips_core and external memory, replacing the fixed pause=0 tie-off.
- Handles memory wait states through mem_ready_i, and aborts hung accesses with a timeout.

Parameters:
- TIMEOUT, 16: maximum cycles the arbiter waits for mem_ready_i before aborting (minimum 2).
- STARVE_LIMIT, 8: consecutive core cycles an ext request may wait before it is forced ahead of the next core cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_i  in  1  core requests an instruction fetch this core cycle
- if_addr_i  in  32  fetch address (zz_pc_o)
- if_data_o  out  32  fetched instruction, registered
- d_rd_i  in  1  core data read request
- d_wr_en_i  in  4  core byte write enables
- d_addr_i  in  32  data address
- d_wdata_i  in  32  write data
- d_rdata_o  out  32  read data, registered
- pause_o  out  1  stall the core pipeline
- ext_req_i  in  1  external master request, level, held until ext_done_o
- ext_addr_i  in  32  ext address
- ext_wr_en_i  in  4  ext byte write enables (0 = read)
- ext_wdata_i  in  32  ext write data
- ext_gnt_o  out  1  ext owns the port (high from grant to done)
- ext_done_o  out  1  one-cycle pulse: ext transfer complete
- ext_rdata_o  out  32  ext read data, valid with ext_done_o
- mem_cs_o  out  1  memory access active
- mem_addr_o  out  32  memory address
- mem_wr_en_o  out  4  memory byte write enables
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data
- mem_ready_i  in  1  access completes this cycle
- err_o  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all counters and done flags clear.
  - All outputs are 0, including pause_o, if_data_o and d_rdata_o.
- A core access is any of: d_rd_i=1, d_wr_en_i≠0, or if_req_i=1.
- FSM states: IDLE, DATA, FETCH, EXT, RELEASE.
- IDLE:
  - Forced ext grant: if ext_req_i=1 and starve_cnt=STARVE_LIMIT, go to EXT.
  - Otherwise, if a data access is pending and not done, go to DATA.
  - Else, if a fetch is pending and not done, go to FETCH.
  - Else, if ext_req_i=1, go to EXT.
- DATA / FETCH / EXT:
  - mem_cs_o=1 and the winner's address, byte enables and write data are driven on the mem_* outputs.
  - The transfer completes on the first cycle with mem_ready_i=1, and mem_rdata_i is captured into the winner's read register.
  - With zero wait states, the transfer takes exactly 1 cycle.
- Transitions:
  - DATA completes → FETCH if a fetch is pending, else RELEASE.
  - FETCH completes → RELEASE.
  - EXT completes → IDLE, pulsing ext_done_o on the completion cycle.
- Writes: d_rdata_o is not updated on data writes.
- RELEASE:
  - pause_o=0 for exactly that one cycle; the core advances on that edge.
  - The done flags clear.
  - starve_cnt increments if ext_req_i=1, and saturates at STARVE_LIMIT.
  - Next state is IDLE.
- pause_o is 1 in every cycle where a core access is pending and the FSM is not in RELEASE; it is 0 when no core access is pending.
- Core latency with zero wait states:
  - fetch only: 2 cycles per instruction;
  - data + fetch: 3 cycles per instruction.
- Every wait state adds 1 cycle to the corresponding transfer.
- Core request signals must be held stable while pause_o=1. Changes during pause are ignored until RELEASE.
- Ext grant:
  - ext_gnt_o rises on entry to EXT and falls after ext_done_o.
  - An ext transfer is never preempted.
  - starve_cnt clears when EXT is entered.
- Timeout:
  - wait_cnt counts cycles in DATA/FETCH/EXT without mem_ready_i.
  - When wait_cnt reaches TIMEOUT-1 with no ready, the transfer aborts:
    - the captured read data is 0x00000000;
    - err_o pulses;
    - the FSM proceeds exactly as if the transfer had completed.
- Simultaneous events:
  - mem_ready_i and the timeout in the same cycle: ready wins, no err_o.
  - ext_req_i deasserted while the FSM is in EXT: ignored (protocol violation); the transfer finishes.
- Reset mid-transfer: mem_cs_o drops immediately (asynchronous) and no done or err pulse is generated.

Decomposition:
- FSM state encoding (3-bit) and the default TIMEOUT/STARVE_LIMIT localparams go in mips789_defs as `define constants.
- Sub-module arb_wait_timer is natural: a counter with clear/enable, producing the timeout strobe; one instance.

Test Plan:
- Reset, then fetch-only stream with mem_ready_i=1:
  - pause_o pattern 1,0 repeating;
  - if_data_o equals mem_rdata_i from the FETCH cycle.
- Load at 0x100 plus fetch at 0x40, zero wait:
  - mem_addr_o = 0x100 then 0x40;
  - d_rdata_o and if_data_o captured;
  - pause_o low only on the 3rd cycle.
- Store d_wr_en_i=4'b0011, 2 wait states:
  - mem_wr_en_o=0011 held for 3 cycles;
  - d_rdata_o unchanged;
  - RELEASE occurs after the fetch.
- ext_req_i held with a continuous core fetch stream:
  - ext granted after exactly STARVE_LIMIT=8 RELEASE cycles;
  - ext_done_o pulses once;
  - ext_rdata_o is correct.
- mem_ready_i held low during a data read:
  - err_o pulses after TIMEOUT=16 cycles;
  - d_rdata_o=0;
  - the FSM continues to FETCH.
- rst asserted mid-EXT with 3 wait states remaining:
  - mem_cs_o and ext_gnt_o drop immediately;
  - no ext_done_o;
  - after release the FSM is in IDLE.
